alu8bit_sequencer: RTL and testbench

//  Queues 18-bit ALU instructions from an upstream requester and issues them one per cycle
//  to an internal alu8bit instance (combinational: A, B, Opcode -> Y, Y1, C, O).

---
 rtl/alu8bit_sequencer_pkg.sv | 28 ++
 rtl/alu8bit_sequencer_if.sv | 27 ++
 rtl/alu8bit_sequencer_alu.sv | 50 +++++
 rtl/alu8bit_sequencer_fifo.sv | 50 +++++
 rtl/alu8bit_sequencer.sv | 112 +++++++++++
 tb/tb_alu8bit_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu8bit_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: instruction field
// positions, opcode names and the issue-control FSM states.
package alu8bit_sequencer_pkg;

  localparam int unsigned INSTR_W = 18;
  localparam int unsigned OP_HI   = 17;
  localparam int unsigned OP_LO   = 16;
  localparam int unsigned A_HI    = 15;
  localparam int unsigned A_LO    = 8;
  localparam int unsigned B_HI    = 7;
  localparam int unsigned B_LO    = 0;

  // OP_0 add, OP_1 subtract, OP_2 unsigned multiply, OP_3 and/xor
  typedef enum logic [1:0] {
    OP_0 = 2'd0,
    OP_1 = 2'd1,
    OP_2 = 2'd2,
    OP_3 = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/alu8bit_sequencer_if.sv
// Instruction-in / result-out handshake bundle of the ALU sequencer.
interface alu8bit_sequencer_if;
  import alu8bit_sequencer_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               instr_vld;
  logic               instr_rdy;
  logic               res_vld;
  logic               res_rdy;
  logic [7:0]         res_y;
  logic [7:0]         res_y1;
  logic               res_c;
  logic               res_o;
  logic [1:0]         res_op;

  // requester / consumer side
  modport master (
    output instr, instr_vld, res_rdy,
    input  instr_rdy, res_vld, res_y, res_y1, res_c, res_o, res_op
  );

  // sequencer side
  modport slave (
    input  instr, instr_vld, res_rdy,
    output instr_rdy, res_vld, res_y, res_y1, res_c, res_o, res_op
  );
endinterface

// File: rtl/alu8bit_sequencer_alu.sv
// Combinational 8-bit ALU: add, subtract, multiply, logic.
module alu8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [1:0] Opcode,
  output logic [7:0] Y,
  output logic [7:0] Y1,
  output logic       C,
  output logic       O
);
  import alu8bit_sequencer_pkg::*;

  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [15:0] prod;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};
  assign prod = {8'h00, A} * {8'h00, B};

  // Opcode decode; C is carry/borrow/high-half-nonzero, O is signed overflow
  always_comb begin
    Y  = '0;
    Y1 = '0;
    C  = 1'b0;
    O  = 1'b0;
    case (Opcode)
      OP_0: begin
        Y = sum[7:0];
        C = sum[8];
        O = (A[7] == B[7]) && (sum[7] != A[7]);
      end
      OP_1: begin
        Y = diff[7:0];
        C = diff[8];
        O = (A[7] != B[7]) && (diff[7] != A[7]);
      end
      OP_2: begin
        Y  = prod[7:0];
        Y1 = prod[15:8];
        C  = |prod[15:8];
      end
      OP_3: begin
        Y  = A & B;
        Y1 = A ^ B;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu8bit_sequencer_fifo.sv
// Instruction FIFO with a separate occupancy counter for full/empty.
module alu_instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         one_left
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign one_left = (cnt_q == (AW+1)'(1));
  assign head     = mem_q[rd_q];

  // Storage array, written at the tail on push
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/alu8bit_sequencer.sv
// Queues ALU instructions, issues one per cycle, registers results with
// flags on a valid/ready port and counts overflow events.
module alu8bit_sequencer
  import alu8bit_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu8bit_sequencer_if.slave   bus,
  input  logic                 flush,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     ovf_count,
  output logic                 busy
);
  logic [INSTR_W-1:0] head;
  logic               full, empty, one_left;
  logic               push, issue;
  logic [7:0]         alu_y, alu_y1;
  logic               alu_c, alu_o;
  logic               res_vld_q;
  logic [7:0]         res_y_q, res_y1_q;
  logic               res_c_q, res_o_q;
  logic [1:0]         res_op_q;
  logic [CNT_W-1:0]   ovf_q;
  state_e             state_q;
  logic               nxt_empty, nxt_vld, stalled;

  assign push  = bus.instr_vld && !full && !flush;
  assign issue = !empty && (!res_vld_q || bus.res_rdy) && !flush;

  alu_instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (push),
    .pop      (issue),
    .din      (bus.instr),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .one_left (one_left)
  );

  alu8bit u_alu (
    .A      (head[A_HI:A_LO]),
    .B      (head[B_HI:B_LO]),
    .Opcode (head[OP_HI:OP_LO]),
    .Y      (alu_y),
    .Y1     (alu_y1),
    .C      (alu_c),
    .O      (alu_o)
  );

  // Result valid: set on issue, cleared on drain or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            res_vld_q <= 1'b0;
    else if (flush)        res_vld_q <= 1'b0;
    else if (issue)        res_vld_q <= 1'b1;
    else if (bus.res_rdy)  res_vld_q <= 1'b0;
  end

  // Result payload changes only on issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_y_q  <= '0;
      res_y1_q <= '0;
      res_c_q  <= 1'b0;
      res_o_q  <= 1'b0;
      res_op_q <= '0;
    end else if (issue) begin
      res_y_q  <= alu_y;
      res_y1_q <= alu_y1;
      res_c_q  <= alu_c;
      res_o_q  <= alu_o;
      res_op_q <= head[OP_HI:OP_LO];
    end
  end

  // Saturating overflow counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ovf_q <= '0;
    else if (stat_clr)                      ovf_q <= '0;
    else if (issue && alu_o && ovf_q != '1) ovf_q <= ovf_q + CNT_W'(1);
  end

  // State is derived from next-cycle occupancy and result status, so IDLE
  // exactly tracks "FIFO empty and no result pending" and busy can be registered.
  assign nxt_empty = flush || (empty && !push) || (one_left && issue && !push);
  assign nxt_vld   = !flush && (issue || (res_vld_q && !bus.res_rdy));
  assign stalled   = res_vld_q && !bus.res_rdy && !empty;

  // Issue-control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      state_q <= IDLE;
    else if (nxt_empty && !nxt_vld)  state_q <= IDLE;
    else if (nxt_empty)              state_q <= DRAIN;
    else if (stalled)                state_q <= STALL;
    else                             state_q <= RUN;
  end

  assign bus.instr_rdy = !full;
  assign bus.res_vld   = res_vld_q;
  assign bus.res_y     = res_y_q;
  assign bus.res_y1    = res_y1_q;
  assign bus.res_c     = res_c_q;
  assign bus.res_o     = res_o_q;
  assign bus.res_op    = res_op_q;
  assign ovf_count     = ovf_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_alu8bit_sequencer.sv
// Directed bench for alu8bit_sequencer: vector table plus multi-cycle sequences.
module tb_alu8bit_sequencer;
  import alu8bit_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, flush, stat_clr;
  logic [7:0] ovf_count;
  logic       busy;

  alu8bit_sequencer_if bus_if ();

  alu8bit_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .flush     (flush),
    .stat_clr  (stat_clr),
    .ovf_count (ovf_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] instr;
    logic [1:0]  op;
    logic [7:0]  y;
    logic [7:0]  y1;
    logic        c;
    logic        o;
  } vec_t;

  vec_t        tbl [12];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_results = 0;
  logic [19:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic int find(input logic [17:0] ins);
    for (int i = 0; i < 12; i++) if (tbl[i].instr == ins) return i;
    return -1;
  endfunction

  // Scoreboard: log accepted instructions, check each consumed result in order
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (bus_if.res_vld && bus_if.res_rdy) begin
        n_results++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got op %0d y 0x%0h, required no result",
                   bus_if.res_op, bus_if.res_y);
        end else begin
          check("result", 32'({bus_if.res_op, bus_if.res_y, bus_if.res_y1, bus_if.res_c, bus_if.res_o}),
                32'(exp_q.pop_front()));
        end
      end
      if (bus_if.instr_vld && bus_if.instr_rdy) begin
        int idx;
        idx = find(bus_if.instr);
        if (idx < 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_lookup: got instr 0x%0h, required a table entry", bus_if.instr);
        end else begin
          exp_q.push_back({tbl[idx].op, tbl[idx].y, tbl[idx].y1, tbl[idx].c, tbl[idx].o});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input int max, input string name);
    int k = 0;
    while (!bus_if.res_vld && k < max) begin
      step();
      k++;
    end
    check(name, 32'(bus_if.res_vld), 1);
  endtask

  task automatic wait_idle(input int max, input string name);
    int k = 0;
    while (busy && k < max) begin
      step();
      k++;
    end
    check(name, 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_vld"}, 32'(bus_if.res_vld), 0);
    check({tag, "_res_y"},   32'(bus_if.res_y), 0);
    check({tag, "_res_y1"},  32'(bus_if.res_y1), 0);
    check({tag, "_res_c"},   32'(bus_if.res_c), 0);
    check({tag, "_res_o"},   32'(bus_if.res_o), 0);
    check({tag, "_res_op"},  32'(bus_if.res_op), 0);
    check({tag, "_ovf"},     32'(ovf_count), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_rdy"},     32'(bus_if.instr_rdy), 1);
  endtask

  task automatic pulse_stat_clr();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
  endtask

  initial begin
    logic [17:0] seq [6];
    int acc, base;

    //            instr      op    Y      Y1     C     O
    tbl[0]  = '{18'h00604, 2'd0, 8'h0A, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{18'h10604, 2'd1, 8'h02, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{18'h20604, 2'd2, 8'h18, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{18'h30604, 2'd3, 8'h04, 8'h02, 1'b0, 1'b0};
    tbl[4]  = '{18'h080F0, 2'd0, 8'h70, 8'h00, 1'b1, 1'b1};
    tbl[5]  = '{18'h10305, 2'd1, 8'hFE, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{18'h18001, 2'd1, 8'h7F, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{18'h2FFFF, 2'd2, 8'h01, 8'hFE, 1'b1, 1'b0};
    tbl[8]  = '{18'h21010, 2'd2, 8'h00, 8'h01, 1'b1, 1'b0};
    tbl[9]  = '{18'h3F03C, 2'd3, 8'h30, 8'hCC, 1'b0, 1'b0};
    tbl[10] = '{18'h07F01, 2'd0, 8'h80, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{18'h0FF01, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0};

    rst_n            = 1'b0;
    flush            = 1'b0;
    stat_clr         = 1'b0;
    bus_if.instr     = '0;
    bus_if.instr_vld = 1'b0;
    bus_if.res_rdy   = 1'b1;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Back-to-back issue: first result one cycle after first accept
    bus_if.instr_vld = 1'b1;
    bus_if.instr = 18'h00604; step();
    check("t1_lat", 32'(bus_if.res_vld), 0);
    bus_if.instr = 18'h10604; step();
    check("t1_vld0", 32'(bus_if.res_vld), 1); check("t1_op0", 32'(bus_if.res_op), 0);
    bus_if.instr = 18'h20604; step();
    check("t1_vld1", 32'(bus_if.res_vld), 1); check("t1_op1", 32'(bus_if.res_op), 1);
    bus_if.instr = 18'h30604; step();
    check("t1_vld2", 32'(bus_if.res_vld), 1); check("t1_op2", 32'(bus_if.res_op), 2);
    bus_if.instr_vld = 1'b0; step();
    check("t1_vld3", 32'(bus_if.res_vld), 1); check("t1_op3", 32'(bus_if.res_op), 3);
    step();
    check("t1_drained", 32'(bus_if.res_vld), 0);
    check("t1_busy", 32'(busy), 0);

    // Table vectors one at a time
    pulse_stat_clr();
    check("tbl_ovf_clr", 32'(ovf_count), 0);
    for (int i = 0; i < 12; i++) begin
      bus_if.instr     = tbl[i].instr;
      bus_if.instr_vld = 1'b1;
      step();
      bus_if.instr_vld = 1'b0;
      wait_vld(4, $sformatf("tbl%0d_vld", i));
      check($sformatf("tbl%0d_y", i),  32'(bus_if.res_y),  32'(tbl[i].y));
      check($sformatf("tbl%0d_y1", i), 32'(bus_if.res_y1), 32'(tbl[i].y1));
      check($sformatf("tbl%0d_c", i),  32'(bus_if.res_c),  32'(tbl[i].c));
      check($sformatf("tbl%0d_o", i),  32'(bus_if.res_o),  32'(tbl[i].o));
      check($sformatf("tbl%0d_op", i), 32'(bus_if.res_op), 32'(tbl[i].op));
      step();
    end
    check("tbl_ovf_total", 32'(ovf_count), 3);

    // Overflow event and stat_clr
    pulse_stat_clr();
    bus_if.instr = 18'h080F0; bus_if.instr_vld = 1'b1; step();
    bus_if.instr_vld = 1'b0;
    wait_vld(4, "t2_vld");
    check("t2_res_o", 32'(bus_if.res_o), 1);
    check("t2_ovf1", 32'(ovf_count), 1);
    step();
    pulse_stat_clr();
    check("t2_ovf_clr", 32'(ovf_count), 0);
    // stat_clr in the same cycle as an overflowing issue
    bus_if.instr_vld = 1'b1; step();
    bus_if.instr_vld = 1'b0; stat_clr = 1'b1; step();
    stat_clr = 1'b0;
    check("t2_prio_vld", 32'(bus_if.res_vld), 1);
    check("t2_prio_o", 32'(bus_if.res_o), 1);
    check("t2_prio_ovf", 32'(ovf_count), 0);
    step();

    // Backpressure: fill FIFO behind a held result, then drain in order
    seq[0] = 18'h00604; seq[1] = 18'h10604; seq[2] = 18'h20604;
    seq[3] = 18'h30604; seq[4] = 18'h2FFFF; seq[5] = 18'h3F03C;
    bus_if.res_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus_if.instr = seq[i]; bus_if.instr_vld = 1'b1;
      @(negedge clk);
      if (bus_if.instr_rdy) acc++;
      step();
    end
    check("t3_accepts", 32'(acc), 5);
    for (int i = 0; i < 3; i++) begin
      check("t3_full", 32'(bus_if.instr_rdy), 0);
      check("t3_hold_vld", 32'(bus_if.res_vld), 1);
      check("t3_hold_y", 32'(bus_if.res_y), 32'h0A);
      check("t3_hold_op", 32'(bus_if.res_op), 0);
      step();
    end
    bus_if.instr_vld = 1'b0;
    base = n_results;
    bus_if.res_rdy = 1'b1;
    step();
    wait_idle(20, "t3_drain_idle");
    check("t3_drained_count", 32'(n_results - base), 5);
    check("t3_sb_empty", 32'(exp_q.size()), 0);

    // Saturation of ovf_count
    pulse_stat_clr();
    bus_if.instr = 18'h080F0; bus_if.instr_vld = 1'b1;
    repeat (260) step();
    bus_if.instr_vld = 1'b0;
    wait_idle(10, "t4_idle");
    check("t4_ovf_sat", 32'(ovf_count), 255);
    bus_if.instr_vld = 1'b1; step(); step();
    bus_if.instr_vld = 1'b0;
    wait_idle(10, "t4_idle2");
    check("t4_ovf_hold", 32'(ovf_count), 255);

    // Flush with 3 queued and a result pending, push dropped
    bus_if.res_rdy = 1'b0;
    bus_if.instr_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.instr = seq[i];
      step();
    end
    check("t5_pre_busy", 32'(busy), 1);
    check("t5_pre_vld", 32'(bus_if.res_vld), 1);
    bus_if.instr = 18'h21010; flush = 1'b1; step();
    flush = 1'b0; bus_if.instr_vld = 1'b0;
    check("t5_vld", 32'(bus_if.res_vld), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_rdy", 32'(bus_if.instr_rdy), 1);
    check("t5_ovf", 32'(ovf_count), 255);
    base = n_results;
    bus_if.res_rdy = 1'b1;
    repeat (8) step();
    check("t5_no_results", 32'(n_results - base), 0);
    check("t5_vld_after", 32'(bus_if.res_vld), 0);

    // Asynchronous reset mid-stream with 2 queued
    bus_if.res_rdy = 1'b0;
    bus_if.instr_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_if.instr = seq[i];
      step();
    end
    bus_if.instr_vld = 1'b0;
    check("t6_pre_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_rdy", 32'(bus_if.instr_rdy), 1);
    check("t6_busy", 32'(busy), 0);
    base = n_results;
    bus_if.res_rdy = 1'b1;
    repeat (6) step();
    check("t6_no_stale", 32'(n_results - base), 0);
    check("t6_vld", 32'(bus_if.res_vld), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
